inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- CPU-side interrupt-acknowledge sequencer that sits directly downstream of the 8259-style PIC.
- Synchronises the PIC's asynchronous INT output.
- Generates the two-pulse active-low INTA handshake and captures the vector byte the PIC drives on its data output during the second pulse.
- Presents the vector to the CPU core with a valid/ack handshake.

Parameters:
- PULSE_CYC, 2, INTA low width in clk cycles per pulse (legal 1..15).
- GAP_CYC, 2, INTA high time in clk cycles after each pulse (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- int_in  input  1  PIC INT output; asynchronous to clk.
- cpu_ie  input  1  CPU interrupt enable; level.
- pic_dout  input  8  PIC data output; carries the vector during the second INTA pulse.
- inta_n  output  1  INTA strobe to the PIC; active low.
- vec_valid  output  1  vector available to the CPU.
- vec_data  output  8  captured vector byte.
- cpu_ack  input  1  CPU has consumed the vector.
- busy  output  1  sequence in progress (any state except IDLE).
- spurious  output  1  INT was lost before the second pulse; valid with vec_valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, inta_n=1, vec_valid=0, vec_data=8'h00, busy=0, spurious=0.
  - Synchroniser flops=0, counter=0.
- int_in passes through a 2-flop synchroniser to produce int_s; int_s lags int_in by 2 clk edges.
- States: IDLE, P1, G1, P2, G2, HOLD.
  - IDLE: if int_s && cpu_ie, go to P1 next cycle; counter loads PULSE_CYC-1.
  - P1: inta_n=0. Decrement counter; at 0, go to G1 with counter=GAP_CYC-1.
  - G1: inta_n=1. At counter 0, go to P2 with counter=PULSE_CYC-1.
    - If int_s==0 on any G1 cycle, set a sticky spurious_pend.
    - The sequence still completes; the PIC requires both pulses.
  - P2: inta_n=0. On the cycle the counter is 0 (last low cycle):
    - vec_data<=pic_dout, spurious<=spurious_pend.
    - Go to G2 with counter=GAP_CYC-1.
  - G2: inta_n=1. At counter 0, go to HOLD and set vec_valid=1.
  - HOLD: vec_valid=1, vec_data stable. On cpu_ack: vec_valid<=0, spurious<=0, spurious_pend<=0, go to IDLE.
- inta_n is registered (glitch-free) and toggles only on state transitions.
- Latency, int_s rising to inta_n first falling: 1 clk.
- Total sequence length: 2*(PULSE_CYC+GAP_CYC) cycles, then vec_valid.
- cpu_ie deasserting after leaving IDLE does not abort the sequence; it only gates entry from IDLE.
- cpu_ack outside HOLD is ignored.
- Back-to-back: from IDLE the block re-enters P1 the cycle after HOLD exit if int_s is still high (AEOI / nested request); no extra holdoff.
- vec_data holds its last value after ack until the next capture.
- Reset asserted mid-sequence:
  - Immediate return to reset values, with inta_n forced high.
  - A partially issued INTA pair is abandoned; the PIC is expected to be reinitialised.
- Counters are 4 bits; PULSE_CYC=1 or GAP_CYC=1 gives a single-cycle state.

Test Plan:
- Reset check: hold rst_n=0 with int_in=1 -> inta_n=1, vec_valid=0, vec_data=00, busy=0. Release -> P1 entered exactly 3 clk later (2 sync + 1).
- Normal acknowledge, PULSE_CYC=2, GAP_CYC=2, int_in=1, cpu_ie=1, pic_dout=8'b01010101 during P2 -> inta_n pattern 0,0,1,1,0,0,1,1. vec_valid rises 8 clk after P1 entry; vec_data=8'h55, spurious=0. cpu_ack=1 for one cycle -> vec_valid=0, busy=0.
- Masked CPU: int_in=1, cpu_ie=0 for 20 cycles -> inta_n stays 1, busy=0. Raise cpu_ie -> sequence starts next cycle.
- Spurious: int_in drops during G1, pic_dout=8'h57 -> second pulse still issued; vec_data=8'h57, spurious=1. After ack, spurious=0.
- Back-to-back: int_in held high through ack, pic_dout=8'h52 then 8'h53 -> second P1 begins the cycle after HOLD exit; second vec_data=8'h53.
- Reset mid-P2: assert rst_n=0 while inta_n=0 -> inta_n=1 and vec_valid=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: synchronises the PIC INT line, issues the two-pulse INTA handshake,
// captures the vector on the second pulse and hands it to the CPU with valid/ack.
module inta_sequencer #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    input  logic       cpu_ie,
    input  logic [7:0] pic_dout,
    input  logic       cpu_ack,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       busy,
    output logic       spurious
);
    typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, HOLD} state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       sync1;
    logic       int_s;
    logic       spurious_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            sync1         <= 1'b0;
            int_s         <= 1'b0;
            spurious_pend <= 1'b0;
            inta_n        <= 1'b1;
            vec_valid     <= 1'b0;
            vec_data      <= 8'h00;
            busy          <= 1'b0;
            spurious      <= 1'b0;
        end else begin
            sync1 <= int_in;
            int_s <= sync1;
            case (state)
                IDLE: if (int_s && cpu_ie) begin
                    state  <= P1;
                    inta_n <= 1'b0;
                    busy   <= 1'b1;
                    cnt    <= PULSE_LD;
                end
                P1: if (cnt == 4'd0) begin
                    state  <= G1;
                    inta_n <= 1'b1;
                    cnt    <= GAP_LD;
                end else cnt <= cnt - 4'd1;
                G1: begin
                    // INT vanishing between pulses marks the vector as spurious,
                    // but the PIC still needs its second pulse.
                    if (!int_s) spurious_pend <= 1'b1;
                    if (cnt == 4'd0) begin
                        state  <= P2;
                        inta_n <= 1'b0;
                        cnt    <= PULSE_LD;
                    end else cnt <= cnt - 4'd1;
                end
                P2: if (cnt == 4'd0) begin
                    state    <= G2;
                    inta_n   <= 1'b1;
                    cnt      <= GAP_LD;
                    vec_data <= pic_dout;
                    spurious <= spurious_pend;
                end else cnt <= cnt - 4'd1;
                G2: if (cnt == 4'd0) begin
                    state     <= HOLD;
                    vec_valid <= 1'b1;
                end else cnt <= cnt - 4'd1;
                HOLD: if (cpu_ack) begin
                    state         <= IDLE;
                    vec_valid     <= 1'b0;
                    spurious      <= 1'b0;
                    spurious_pend <= 1'b0;
                    busy          <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    inta_n    <= 1'b1;
                    vec_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: directed scenarios plus random traffic, checked every cycle
// against a cycle-index model of the INTA sequence.
module tb_inta_sequencer;
    localparam int P = 2;
    localparam int G = 2;
    localparam int L = 2 * (P + G);

    logic       clk = 1'b0, rst_n = 1'b0, int_in = 1'b0, cpu_ie = 1'b0, cpu_ack = 1'b0;
    logic [7:0] pic_dout = 8'h00;
    logic       inta_n, vec_valid, busy, spurious;
    logic [7:0] vec_data;
    int         n_chk = 0, n_pass = 0;

    inta_sequencer #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n), .int_in(int_in), .cpu_ie(cpu_ie), .pic_dout(pic_dout),
        .inta_n(inta_n), .vec_valid(vec_valid), .vec_data(vec_data), .cpu_ack(cpu_ack),
        .busy(busy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    // Model: m_k counts cycles since the first INTA low cycle; pulses occupy
    // [0,P) and [P+G,2P+G), vector is sampled on cycle 2P+G-1, HOLD after L cycles.
    logic       m_s1, m_s2, m_act, m_hold, m_pend, m_spur;
    int         m_k;
    logic [7:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_act <= 1'b0; m_hold <= 1'b0;
            m_pend <= 1'b0; m_spur <= 1'b0; m_k <= 0; m_data <= 8'h00;
        end else begin
            m_s1 <= int_in;
            m_s2 <= m_s1;
            if (m_hold) begin
                if (cpu_ack) begin
                    m_hold <= 1'b0; m_spur <= 1'b0; m_pend <= 1'b0;
                end
            end else if (m_act) begin
                if (m_k >= P && m_k < P + G && !m_s2) m_pend <= 1'b1;
                if (m_k == 2 * P + G - 1) begin
                    m_data <= pic_dout; m_spur <= m_pend;
                end
                if (m_k == L - 1) begin
                    m_act <= 1'b0; m_hold <= 1'b1;
                end else m_k <= m_k + 1;
            end else if (m_s2 && cpu_ie) begin
                m_act <= 1'b1; m_k <= 0;
            end
        end
    end

    function automatic logic exp_inta();
        return !(m_act && (m_k < P || (m_k >= P + G && m_k < 2 * P + G)));
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        check("inta_n", inta_n, exp_inta());
        check("vec_valid", vec_valid, m_hold);
        check("vec_data", vec_data, m_data);
        check("busy", busy, m_act | m_hold);
        check("spurious", spurious, m_spur);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!vec_valid && n < 50) begin tick(); n++; end
        check("valid_seen", vec_valid, 1'b1);
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("ack_valid", vec_valid, 1'b0);
        check("ack_busy", busy, 1'b0);
        check("ack_spur", spurious, 1'b0);
    endtask

    task automatic wait_p1();
        int n = 0;
        while (inta_n && n < 50) begin tick(); n++; end
        check("p1_seen", inta_n, 1'b0);
    endtask

    initial begin
        int n;
        // Reset with INT already asserted
        int_in = 1'b1; cpu_ie = 1'b1;
        repeat (3) tick();
        check("rst_inta", inta_n, 1'b1);
        check("rst_valid", vec_valid, 1'b0);
        check("rst_data", vec_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        n = 0;
        while (inta_n && n < 10) begin tick(); n++; end
        check("p1_latency", 8'(n), 8'd3);

        // Normal acknowledge, then back-to-back with INT still high
        pic_dout = 8'h55;
        wait_valid(n);
        check("valid_latency", 8'(n), 8'(L));
        check("norm_data", vec_data, 8'h55);
        check("norm_spur", spurious, 1'b0);
        pic_dout = 8'h53;
        ack();
        tick();
        check("b2b_p1", inta_n, 1'b0);
        wait_valid(n);
        check("b2b_data", vec_data, 8'h53);
        check("b2b_spur", spurious, 1'b0);
        int_in = 1'b0;
        repeat (3) tick();
        ack();
        repeat (3) tick();
        check("idle_after", busy, 1'b0);

        // INT lost right after the first pulse starts -> spurious
        pic_dout = 8'h57; int_in = 1'b1;
        wait_p1();
        int_in = 1'b0;
        wait_valid(n);
        check("spur_data", vec_data, 8'h57);
        check("spur_flag", spurious, 1'b1);
        ack();
        tick();
        check("data_held", vec_data, 8'h57);

        // Masked CPU
        cpu_ie = 1'b0; int_in = 1'b1;
        repeat (20) tick();
        check("mask_busy", busy, 1'b0);
        check("mask_inta", inta_n, 1'b1);
        cpu_ie = 1'b1;
        tick();
        check("unmask_p1", inta_n, 1'b0);
        cpu_ie = 1'b0;
        wait_valid(n);
        int_in = 1'b0;
        repeat (3) tick();
        ack();
        cpu_ie = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of the second pulse
        int_in = 1'b1;
        n = 0;
        while (!(m_act && m_k == P + G) && n < 50) begin tick(); n++; end
        check("p2_reached", inta_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_inta", inta_n, 1'b1);
        check("arst_valid", vec_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        int_in = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) int_in = ~int_in;
            cpu_ie   = ($urandom_range(0, 7) != 0);
            pic_dout = 8'($urandom);
            cpu_ack  = ($urandom_range(0, 3) == 0);
            tick();
        end
        cpu_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
